// File: rtl/ntt_addr_seq.sv
// Self-sequencing radix-2 NTT/INTT/MULT/ADDSUB address generator.
// One read pair per cycle, stage-boundary drain bubbles, PIPE_LAT-delayed write-back addresses.
//
// state  | meaning
// IDLE   | waiting for start (blocked during the done pulse)
// ISSUE  | issuing butterfly i = 0..N/2-1 of the current stage
// DRAIN  | PIPE_LAT empty cycles so the stage's writes land before the next stage reads
// DONE   | one cycle; raises done, drops busy
module ntt_addr_seq #(
  parameter int LOG_N      = 8,
  parameter int NUM_STAGES = 7,
  parameter int PIPE_LAT   = 6,
  parameter int SW         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic [SW-1:0]    stage,
  output logic             rd_valid,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-2:0] tw_addr,
  output logic             tw_neg,
  output logic             wr_valid,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b
);

  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam logic [LOG_N-1:0] ONE      = LOG_N'(1);
  localparam logic [LOG_N-1:0] QUARTER  = LOG_N'((1 << LOG_N) / 4);
  localparam logic [LOG_N-2:0] LAST_IDX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic [LOG_N-2:0] idx;
  logic [SW-1:0]    stg;
  logic [DW-1:0]    drain_cnt;
  logic             rd_valid_r;
  logic             last_stage;

  logic [LOG_N-1:0] i_ext, g, j, a_c, b_c, tw_c;
  logic             neg_c;
  int               sh;

  assign last_stage = mode_q[1] ? 1'b1 : (stg == SW'(NUM_STAGES - 1));

  // Butterfly decomposition: sh = log2(len), g = group, j = offset inside group.
  always_comb begin
    i_ext = {1'b0, idx};
    sh    = 0;
    g     = '0;
    j     = '0;
    a_c   = '0;
    b_c   = '0;
    tw_c  = '0;
    neg_c = 1'b0;
    case (mode_q)
      2'd0, 2'd1: begin
        sh   = (mode_q == 2'd0) ? (LOG_N - 1 - int'(stg)) : (int'(stg) + 1);
        g    = i_ext >> sh;
        j    = i_ext & ((ONE << sh) - ONE);
        a_c  = (g << (sh + 1)) + j;
        b_c  = a_c + (ONE << sh);
        tw_c = (mode_q == 2'd0) ? ((ONE << stg) + g)
                                : ((ONE << (LOG_N - sh)) - ONE - g);
      end
      2'd2: begin
        a_c   = {idx, 1'b0};
        b_c   = {idx, 1'b1};
        tw_c  = QUARTER + (i_ext >> 1);
        neg_c = idx[0];
      end
      default: begin
        a_c = {idx, 1'b0};
        b_c = {idx, 1'b1};
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      mode_q     <= 2'd0;
      idx        <= '0;
      stg        <= '0;
      drain_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      stage      <= '0;
      rd_valid_r <= 1'b0;
      rd_addr_a  <= '0;
      rd_addr_b  <= '0;
      tw_addr    <= '0;
      tw_neg     <= 1'b0;
    end else if (!hold) begin
      rd_valid_r <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          // done is still high here for one cycle after DONE; a start then is ignored
          if (start && !done) begin
            state  <= S_ISSUE;
            mode_q <= mode;
            idx    <= '0;
            stg    <= '0;
          end
        end
        S_ISSUE: begin
          busy       <= 1'b1;
          rd_valid_r <= 1'b1;
          rd_addr_a  <= a_c;
          rd_addr_b  <= b_c;
          tw_addr    <= tw_c[LOG_N-2:0];
          tw_neg     <= neg_c;
          stage      <= stg;
          idx        <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state     <= S_DRAIN;
            drain_cnt <= DW'(PIPE_LAT - 1);
          end
        end
        S_DRAIN: begin
          busy <= 1'b1;
          if (drain_cnt == '0) begin
            if (last_stage) begin
              state <= S_DONE;
            end else begin
              stg   <= stg + 1'b1;
              state <= S_ISSUE;
            end
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  logic             sr_v [PIPE_LAT];
  logic [LOG_N-1:0] sr_a [PIPE_LAT];
  logic [LOG_N-1:0] sr_b [PIPE_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        sr_v[k] <= 1'b0;
        sr_a[k] <= '0;
        sr_b[k] <= '0;
      end
    end else if (!hold) begin
      sr_v[0] <= rd_valid_r;
      sr_a[0] <= rd_addr_a;
      sr_b[0] <= rd_addr_b;
      for (int k = 1; k < PIPE_LAT; k++) begin
        sr_v[k] <= sr_v[k-1];
        sr_a[k] <= sr_a[k-1];
        sr_b[k] <= sr_b[k-1];
      end
    end
  end

  assign rd_valid  = rd_valid_r & ~hold;
  assign wr_valid  = sr_v[PIPE_LAT-1] & ~hold;
  assign wr_addr_a = sr_a[PIPE_LAT-1];
  assign wr_addr_b = sr_b[PIPE_LAT-1];

endmodule

// File: tb/tb_ntt_addr_seq.sv
// Bench for ntt_addr_seq: default instance plus a LOG_N=6/5-stage/PIPE_LAT=3 instance,
// compared cycle by cycle against a butterfly-enumeration reference model.
module tb_ntt_addr_seq;

  logic clk = 1'b0;
  logic rst, hold, start1, start2;
  logic [1:0] mode;

  logic       busy1, done1, rv1, neg1, wv1;
  logic [2:0] stg1;
  logic [7:0] ra1, rb1, wa1, wb1;
  logic [6:0] tw1;

  logic       busy2, done2, rv2, neg2, wv2;
  logic [2:0] stg2;
  logic [5:0] ra2, rb2, wa2, wb2;
  logic [4:0] tw2;

  int passed = 0;
  int total  = 0;

  logic [31:0] o_busy, o_done, o_stg, o_rv, o_a, o_b, o_tw, o_neg, o_wv, o_wa, o_wb;

  always #5 clk = ~clk;

  ntt_addr_seq dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .hold(hold),
    .busy(busy1), .done(done1), .stage(stg1), .rd_valid(rv1),
    .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_addr(tw1), .tw_neg(neg1),
    .wr_valid(wv1), .wr_addr_a(wa1), .wr_addr_b(wb1)
  );

  ntt_addr_seq #(.LOG_N(6), .NUM_STAGES(5), .PIPE_LAT(3), .SW(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode), .hold(hold),
    .busy(busy2), .done(done2), .stage(stg2), .rd_valid(rv2),
    .rd_addr_a(ra2), .rd_addr_b(rb2), .tw_addr(tw2), .tw_neg(neg2),
    .wr_valid(wv2), .wr_addr_a(wa2), .wr_addr_b(wb2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic sample(input int sel);
    o_busy = sel ? 32'(busy2) : 32'(busy1);
    o_done = sel ? 32'(done2) : 32'(done1);
    o_stg  = sel ? 32'(stg2)  : 32'(stg1);
    o_rv   = sel ? 32'(rv2)   : 32'(rv1);
    o_a    = sel ? 32'(ra2)   : 32'(ra1);
    o_b    = sel ? 32'(rb2)   : 32'(rb1);
    o_tw   = sel ? 32'(tw2)   : 32'(tw1);
    o_neg  = sel ? 32'(neg2)  : 32'(neg1);
    o_wv   = sel ? 32'(wv2)   : 32'(wv1);
    o_wa   = sel ? 32'(wa2)   : 32'(wa1);
    o_wb   = sel ? 32'(wb2)   : 32'(wb1);
  endtask

  task automatic chk_all_zero(input string tag);
    sample(0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_stage"}, o_stg, 0);
    chk({tag, "_rv"}, o_rv, 0);
    chk({tag, "_a"}, o_a, 0);
    chk({tag, "_b"}, o_b, 0);
    chk({tag, "_tw"}, o_tw, 0);
    chk({tag, "_neg"}, o_neg, 0);
    chk({tag, "_wv"}, o_wv, 0);
    chk({tag, "_wa"}, o_wa, 0);
    chk({tag, "_wb"}, o_wb, 0);
  endtask

  // One pass. k counts unheld cycles after the accepted-start edge (model time).
  task automatic run_pass(input int sel, input int md, input int hold_at, input int hold_len,
                          input int poke_at, input int abort_at);
    int lg, ns, pl, half, nst, p, last_k, k, cyc, s, i, kw, len, gi, budget;
    bit held, fin, aborted, rv_e, wv_e;
    int ea[8][128];
    int eb[8][128];
    int et[8][128];
    int en[8][128];
    lg = sel ? 6 : 8;
    ns = sel ? 5 : 7;
    pl = sel ? 3 : 6;
    half = (1 << lg) / 2;
    nst = (md >= 2) ? 1 : ns;
    p = half + pl;
    last_k = nst * p + 1;
    for (int st = 0; st < nst; st++) begin
      i = 0;
      if (md < 2) begin
        len = (md == 0) ? (half >> st) : (2 << st);
        gi = 0;
        for (int base = 0; base < (1 << lg); base += 2 * len) begin
          for (int jj = base; jj < base + len; jj++) begin
            ea[st][i] = jj;
            eb[st][i] = jj + len;
            et[st][i] = (md == 0) ? ((1 << st) + gi) : ((1 << lg) / len - 1 - gi);
            en[st][i] = 0;
            i++;
          end
          gi++;
        end
      end else begin
        for (int q = 0; q < half; q++) begin
          ea[st][q] = 2 * q;
          eb[st][q] = 2 * q + 1;
          et[st][q] = (md == 2) ? ((1 << lg) / 4 + q / 2) : 0;
          en[st][q] = (md == 2) ? (q % 2) : 0;
        end
      end
    end

    @(negedge clk);
    mode = 2'(md);
    if (sel != 0) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    sample(sel);
    chk("busy_c0", o_busy, 0);
    cyc = 0; k = 0; held = 0; fin = 0; aborted = 0;
    budget = last_k + hold_len + 10;
    while (!fin && !aborted && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (!held) k++;
      held = (cyc >= hold_at) && (cyc < hold_at + hold_len);
      hold = held;
      if (sel != 0) start2 = (cyc == poke_at) || (k == last_k && !held);
      else          start1 = (cyc == poke_at) || (k == last_k && !held);
      if (cyc == abort_at) begin
        rst = 1'b1;
        start1 = 1'b0;
        #1;
        chk_all_zero("abort");
        repeat (3) begin
          @(posedge clk); #1;
          sample(sel);
          chk("abort_nodone", o_done, 0);
        end
        rst = 1'b0;
        aborted = 1;
      end else begin
        #1;
        sample(sel);
        if (held) begin
          chk("hold_rv", o_rv, 0);
          chk("hold_wv", o_wv, 0);
        end else begin
          chk("busy", o_busy, 32'((k >= 1) && (k <= nst * p)));
          chk("done", o_done, 32'(k == last_k));
          s = (k - 1) / p;
          i = (k - 1) % p;
          rv_e = (s < nst) && (i < half);
          chk("rd_valid", o_rv, 32'(rv_e));
          if (rv_e) begin
            chk("rd_a", o_a, ea[s][i]);
            chk("rd_b", o_b, eb[s][i]);
            chk("tw", o_tw, et[s][i]);
            chk("tw_neg", o_neg, en[s][i]);
            chk("stage", o_stg, s);
          end
          kw = k - pl;
          wv_e = 0;
          if (kw >= 1) begin
            s = (kw - 1) / p;
            i = (kw - 1) % p;
            wv_e = (s < nst) && (i < half);
          end
          chk("wr_valid", o_wv, 32'(wv_e));
          if (wv_e) begin
            chk("wr_a", o_wa, ea[s][i]);
            chk("wr_b", o_wb, eb[s][i]);
          end
          if (k == last_k) begin
            chk("done_cycle", cyc, last_k + hold_len);
            fin = 1;
          end
        end
      end
    end
    start1 = 1'b0; start2 = 1'b0; hold = 1'b0;
    if (!aborted && !fin) chk("timeout", cyc, last_k + hold_len);
    if (fin) begin
      repeat (3) begin
        @(posedge clk); #1;
        sample(sel);
        chk("post_busy", o_busy, 0);
        chk("post_rv", o_rv, 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; start1 = 1'b0; start2 = 1'b0; mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (10) @(posedge clk);
    run_pass(0, 0, -1, 0, -1, -1);
    run_pass(0, 1, -1, 0, -1, -1);
    run_pass(0, 2, -1, 0, -1, -1);
    run_pass(0, 0, $urandom_range(100, 800), 5, $urandom_range(20, 900), -1);
    run_pass(0, 0, -1, 0, -1, 300);
    run_pass(0, 3, -1, 0, -1, -1);
    run_pass(1, 0, -1, 0, -1, -1);
    run_pass(1, 1, $urandom_range(10, 150), $urandom_range(1, 6), $urandom_range(5, 170), -1);
    run_pass(0, $urandom_range(0, 3), $urandom_range(5, 120), $urandom_range(1, 8),
             $urandom_range(2, 130), -1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/ntt_addr_seq.md
Name: ntt_addr_seq

Overview:
- Parametrised, self-sequencing address generator for the NTT coefficient memory and twiddle ROM.
- Owns its own stage/butterfly counters and a start/busy/done handshake; no external cycle counter.
- Issues one radix-2 butterfly read pair per cycle and returns matching write-back addresses after a programmable pipeline latency.
- Inserts drain bubbles at stage boundaries so no read hits an unwritten coefficient. Supports NTT, INTT, MULT and ADDSUB passes.

Parameters:
LOG_N, 8, log2 of polynomial length N (N=256); coefficient address width = LOG_N.
NUM_STAGES, 7, butterfly stages per NTT/INTT (Kyber stops at len=2); 1 <= NUM_STAGES <= LOG_N-1.
PIPE_LAT, 6, butterfly read-to-write latency in cycles; >= 1.
SW, 3, stage output width; must be >= clog2(NUM_STAGES).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request; sampled only when busy=0
mode  in  2  0=NTT, 1=INTT, 2=MULT, 3=ADDSUB; latched on accepted start
hold  in  1  global stall; freezes all counters, FSM and write pipeline
busy  out  1  high from cycle after accepted start until done cycle (exclusive)
done  out  1  one-cycle pulse when the pass completes
stage  out  SW  current stage index (0 for MULT/ADDSUB)
rd_valid  out  1  read pair valid this cycle
rd_addr_a  out  LOG_N  butterfly top coefficient address
rd_addr_b  out  LOG_N  butterfly bottom coefficient address
tw_addr  out  LOG_N-1  twiddle ROM index
tw_neg  out  1  negate twiddle (MULT odd pairs)
wr_valid  out  1  write-back pair valid
wr_addr_a  out  LOG_N  write address a (rd_addr_a delayed PIPE_LAT)
wr_addr_b  out  LOG_N  write address b (rd_addr_b delayed PIPE_LAT)

Behaviour:
- Reset: FSM=IDLE; busy=done=rd_valid=wr_valid=tw_neg=0; stage and all addresses 0; pipeline valids cleared. Reset mid-pass aborts the pass with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- Transitions:
  - IDLE -> ISSUE on start (mode latched).
  - ISSUE runs butterfly index i = 0..N/2-1 (rd_valid=1), then -> DRAIN.
  - DRAIN runs PIPE_LAT cycles with rd_valid=0, then -> ISSUE of the next stage, or -> DONE after the last stage.
  - DONE lasts one cycle (done=1, busy=0), then -> IDLE.
- Pass length: NTT and INTT have NUM_STAGES stages; MULT and ADDSUB have 1 stage.
- start while busy, or in the DONE cycle, is ignored.
- hold=1: no state, counter or shift-register update. Outputs stay registered at their current values; rd_valid/wr_valid are gated to 0 while hold=1.
- NTT stage s:
  - len = (N/2)>>s; g = i>>log2(len); j = i mod len.
  - a = g*2*len + j; b = a + len; tw_addr = (1<<s) + g.
- INTT stage t:
  - len = 2<<t; a, b as for NTT.
  - tw_addr = N/len - 1 - g (descending: 127..64 at t=0 for N=256).
- MULT: a = 2i; b = 2i+1; tw_addr = N/4 + (i>>1); tw_neg = i[0].
- ADDSUB: a = 2i; b = 2i+1; tw_addr = 0; tw_neg = 0.
- Address arithmetic is unsigned, LOG_N bits; it never overflows for legal parameters.
- Write pipeline: the valid/addr shift register is PIPE_LAT deep and advances whenever hold=0. wr_* equals rd_* from PIPE_LAT unheld cycles earlier.
- Timing, cycle k after the accepted-start edge with no hold, P = N/2 + PIPE_LAT:
  - stage s issues cycles 1+s*P .. s*P+N/2;
  - last write at cycle S*P; done at S*P+1.

Test Plan:
- Reset, idle 10 cycles, start NTT with defaults -> stage 0 cycle 1: a=0, b=128, tw=1; cycle 128: a=127, b=255; first wr_valid at cycle 7 with wr_a=0, wr_b=128; done at cycle 939, busy low same cycle.
- NTT stage 6 first issue (cycle 805) -> a=0, b=2, tw=64; second -> a=1, b=3, tw=64; third -> a=4, b=6, tw=65; last -> tw=127.
- INTT, defaults -> stage 0 first issue a=0, b=2, tw=127; stage 6 (len=128) a=0, b=128, tw=1; done at cycle 939.
- MULT -> i=0: a=0, b=1, tw=64, neg=0; i=1: a=2, b=3, tw=64, neg=1; i=127: a=254, b=255, tw=127; done at cycle 135.
- hold asserted for 5 cycles mid-stage, plus start pulsed while busy -> addresses resume without skip or duplicate; start ignored; NTT done moves to cycle 944.
- rst asserted at cycle 300 of NTT -> all outputs 0 next edge, no done; fresh ADDSUB start then completes normally, done at cycle 135. Also rerun with LOG_N=6, NUM_STAGES=5, PIPE_LAT=3 -> P=35, done at cycle 176.
